// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one
// BLOCK-wide lookahead group and registers the carry into the next group,
// so no carry ripples across groups within a cycle. Beats enter and leave
// through valid/ready handshakes. The combinational ready chain lets any
// empty stage absorb a beat, so bubbles collapse.
module cla_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             gp,
  output logic             gg
);

  localparam int STAGES = WIDTH / BLOCK;
  localparam int NIB    = BLOCK / 4;

  // One BLOCK-wide lookahead group built as a two-level tree. The lower
  // level is 4-bit nibble generate/propagate. The upper level is a
  // sum-of-products across nibbles. The group G/P come from the same
  // upper-level terms.
  function automatic void cla_block(
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             grp_g,
    output logic             grp_p
  );
    logic [BLOCK-1:0] g, p, c;
    logic [NIB-1:0]   ng, np, nc;
    logic             gen, prop, term;
    g = x & y;
    p = x ^ y;
    for (int n = 0; n < NIB; n++) begin
      np[n] = &p[4*n +: 4];
      ng[n] = g[4*n+3]
            | (p[4*n+3] & g[4*n+2])
            | (p[4*n+3] & p[4*n+2] & g[4*n+1])
            | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
    end
    // Carry into nibble n is the OR of nibble generates below it, each ANDed
    // with the propagates between it and n. It is written flat, not chained.
    grp_g = 1'b0;
    grp_p = 1'b1;
    nc    = '0;
    for (int n = 0; n <= NIB; n++) begin
      gen  = 1'b0;
      prop = 1'b1;
      for (int j = 0; j < n; j++) begin
        term = ng[j];
        for (int m = j + 1; m < n; m++) term &= np[m];
        gen  |= term;
        prop &= np[j];
      end
      if (n < NIB) nc[n] = gen | (prop & ci);
      grp_g = gen;
      grp_p = prop;
    end
    // Inside a nibble the 4-bit carry expression is flattened by synthesis.
    c = '0;
    for (int n = 0; n < NIB; n++) begin
      c[4*n] = nc[n];
      for (int i = 0; i < 3; i++)
        c[4*n+i+1] = g[4*n+i] | (p[4*n+i] & c[4*n+i]);
    end
    s = p ^ c;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * BLOCK;  // sum bits resolved after this stage
    localparam int REM  = WIDTH - DONE;     // operand bits still unresolved

    logic             valid_r, carry_r, gp_r, gg_r, a_msb_r, bx_msb_r;
    logic [DONE-1:0]  sum_r;
    logic             ready_k;

    // Stage inputs. The low BLOCK bits of a_src/bx_src form this stage's group.
    logic                 valid_d, ci_d, a_msb_d, bx_msb_d, gp_d, gg_d;
    logic [REM+BLOCK-1:0] a_src, bx_src;
    logic [DONE-1:0]      sum_d;
    logic [BLOCK-1:0]     s_d;
    logic                 g_d, p_d;

    if (k == 0) begin : g_src
      // Subtract inverts B and forces the carry-in at capture. cin is then ignored.
      assign valid_d  = in_valid;
      assign a_src    = a;
      assign bx_src   = sub ? ~b : b;
      assign ci_d     = sub | cin;
      assign a_msb_d  = a[WIDTH-1];
      assign bx_msb_d = bx_src[WIDTH-1];
      assign sum_d    = s_d;
      assign gp_d     = p_d;
      assign gg_d     = g_d;
    end else begin : g_src
      assign valid_d  = g_stage[k-1].valid_r;
      assign a_src    = g_stage[k-1].g_rem.a_r;
      assign bx_src   = g_stage[k-1].g_rem.bx_r;
      assign ci_d     = g_stage[k-1].carry_r;
      assign a_msb_d  = g_stage[k-1].a_msb_r;
      assign bx_msb_d = g_stage[k-1].bx_msb_r;
      assign sum_d    = {s_d, g_stage[k-1].sum_r};
      assign gp_d     = p_d & g_stage[k-1].gp_r;
      assign gg_d     = g_d | (p_d & g_stage[k-1].gg_r);
    end

    // Resolve this stage's group from the registered carry of the previous one.
    // NOTE: every always_comb output is assigned on every path (here by the
    // function's outputs), so no latch can be inferred.
    always_comb cla_block(a_src[BLOCK-1:0], bx_src[BLOCK-1:0], ci_d, s_d, g_d, p_d);

    // A stage can load when it is empty or when the stage after it moves on.
    if (k == STAGES - 1) begin : g_rdy
      assign ready_k = !valid_r | out_ready;
    end else begin : g_rdy
      assign ready_k = !valid_r | g_stage[k+1].ready_k;
    end

    // Stage register. Data loads only with a valid beat, so the outputs stay
    // put while a result is stalled and while bubbles pass through.
    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge value of its predecessor.
    // NOTE: the data registers are reset as well as the valid bits, so the
    // result outputs read zero after reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r  <= 1'b0;
        carry_r  <= 1'b0;
        gp_r     <= 1'b0;
        gg_r     <= 1'b0;
        a_msb_r  <= 1'b0;
        bx_msb_r <= 1'b0;
        sum_r    <= '0;
      end else if (ready_k) begin
        valid_r <= valid_d;
        if (valid_d) begin
          carry_r  <= g_d | (p_d & ci_d);
          gp_r     <= gp_d;
          gg_r     <= gg_d;
          a_msb_r  <= a_msb_d;
          bx_msb_r <= bx_msb_d;
          sum_r    <= sum_d;
        end
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_r, bx_r;
      // Carry forward the operand bits that later stages still need to resolve.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r  <= '0;
          bx_r <= '0;
        end else if (ready_k && valid_d) begin
          a_r  <= a_src[REM+BLOCK-1:BLOCK];
          bx_r <= bx_src[REM+BLOCK-1:BLOCK];
        end
      end
    end
  end

  assign in_ready  = g_stage[0].ready_k;
  assign out_valid = g_stage[STAGES-1].valid_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].carry_r;
  assign gp        = g_stage[STAGES-1].gp_r;
  assign gg        = g_stage[STAGES-1].gg_r;
  assign ovf       = (g_stage[STAGES-1].a_msb_r == g_stage[STAGES-1].bx_msb_r)
                   & (g_stage[STAGES-1].sum_r[WIDTH-1] != g_stage[STAGES-1].a_msb_r);

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor that succeeds the fixed 64-bit four-group CLA. Each pipeline stage resolves one BLOCK-wide lookahead group and registers the inter-group carry. This gives one result per cycle at high clock rates. Operands enter and results leave through valid/ready handshakes with full backpressure. The block sits in the datapath between operand registers and downstream consumers such as the ALU result mux and accumulators.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must be a multiple of BLOCK.
- BLOCK, 16, group width resolved per stage; legal values are 4, 8 or 16.
- STAGES (localparam), WIDTH/BLOCK, number of pipeline stages, which is also the latency.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  out  1  signed overflow.
- gp  out  1  whole-word group propagate over A and effective B.
- gg  out  1  whole-word group generate over A and effective B.

## Operation
- Effective operands: bx = sub ? ~b : b; c0 = sub ? 1 : cin. The inversion is applied at capture.
- Stage k (k=1..STAGES) resolves bits [k*BLOCK-1:(k-1)*BLOCK] using a 4-bit lookahead sub-tree. Its carry-in is the registered carry from stage k-1; stage 1 uses c0.
- Each stage register holds:
  - valid;
  - resolved sum bits so far;
  - unresolved high bits of a and bx;
  - running carry;
  - running GP/GG;
  - the MSB info needed for ovf.
- Running group terms: GP_acc = GP_k & GP_acc and GG_acc = GG_k | (GP_k & GG_acc), initialised from group 1.
- Final outputs:
  - gp = GP_acc and gg = GG_acc after stage STAGES.
  - cout equals gg | (gp & c0).
  - ovf = (a[W-1] == bx[W-1]) & (sum[W-1] != a[W-1]).
- Handshake:
  - ready_k = !valid_k | ready_{k+1}, with ready_{STAGES+1} = out_ready.
  - in_ready = ready_1. Stage k loads from stage k-1 when ready_k.
  - Bubbles collapse: an empty stage accepts even if downstream is stalled.
- A beat transfers on the input when in_valid & in_ready. It transfers on the output when out_valid & out_ready.
- out_valid = valid_STAGES. sum/cout/ovf/gp/gg are driven from the last stage register and are stable while out_valid & !out_ready.
- Ordering is strictly FIFO. No beat is dropped or duplicated. Capacity is STAGES beats.

## Timing
- Reset (async assert, sync release): all valid bits and all data registers are 0. Outputs are then out_valid=0, sum=0, cout=0, ovf=0, gp=0, gg=0, and in_ready=1.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1. It is visible in the cycle after that edge, i.e. STAGES cycles later, when there is no stall.
- Throughput: 1 beat/cycle with out_ready held 1.
- Full pipe with out_ready=0: in_ready=0 combinationally. On out_ready rising, in_ready=1 in the same cycle (combinational ready chain, no registered ready).
- Simultaneous accept and drain when full: both occur and occupancy is unchanged.
- Reset mid-operation discards all in-flight beats. No output beat follows reset until a new input is accepted.
- in_valid must not be withdrawn before acceptance; a, b, cin and sub must be held stable while in_valid & !in_ready.
- Critical path per stage: one BLOCK lookahead plus the GP/GG merge. There is no ripple across groups within a cycle.

## Test plan
WIDTH=64, BLOCK=16 throughout, so latency is 4.
- Reset, then a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0, cout=1, gp=0, gg=1, ovf=0, with out_valid exactly 4 cycles after acceptance.
- Overflow and subtract:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Full propagate: a=0xAAAA_AAAA_AAAA_AAAA, b=0x5555_5555_5555_5555 with cin=1 -> sum=0, cout=1, gp=1, gg=0. With cin=0 -> sum=all-ones, cout=0.
- Backpressure: stream 10 random beats, out_ready=0 for cycles 3-9. in_ready drops after 4 beats are in flight. All 10 results arrive in order, match the reference model, and outputs hold stable during the stall.
- Bubbles: alternate in_valid 1/0 with out_ready random. Every accepted beat is output exactly once, with no extra out_valid pulses.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 and outputs zero immediately (asynchronously). After release, none of the 3 beats emerge, and a new beat a=1, b=2 gives sum=3 after 4 cycles.
